// File: rtl/adder_tg_pkg.sv
// -----------------------------------------------------------------------------
// adder_tg_pkg
// Shared types, constants and the LFSR step function for the adder traffic
// generator. Contains:
//   tg_state_e   : run-control states IDLE / RUN / DRAIN / DONE
//   LFSR_W       : LFSR width (16)
//   LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_SEED : default LFSR load value
//   CNT_W        : width of the transaction and error counters
//   lfsr_advance : one Galois step of the LFSR
// -----------------------------------------------------------------------------
package adder_tg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tg_state_e;

    localparam int                LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
    localparam int                CNT_W        = 8;

    // Right-shifting Galois step: the bit shifted out of bit 0 folds back
    // into the tap positions.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] shifted;
        shifted = {1'b0, cur[LFSR_W-1:1]};
        if (cur[0]) begin
            return shifted ^ LFSR_TAPS;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR with synchronous reload.
// Ports:
//   clk   in  clock, rising edge
//   reset in  asynchronous active-high reset, loads RESET_VAL
//   load  in  reload from seed this cycle (has priority over step)
//   seed  in  value loaded when load=1
//   step  in  advance one position this cycle
//   q     out current LFSR value
// -----------------------------------------------------------------------------
module lfsr16
    import adder_tg_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    // Next LFSR value: reload wins over step, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
            q_d = lfsr_advance(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/adder_traffic_gen.sv
// -----------------------------------------------------------------------------
// adder_traffic_gen
// Self-contained initiator/checker for a registered adder (a/b/valid -> c).
// A start pulse launches NUM_TXN back-to-back transactions with LFSR-derived
// operands; every expected sum is delayed by ADDER_LATENCY cycles and compared
// with c. After the last result has been checked the block reports done/pass.
//
// Optional feature macro: ADDER_TG_FIRST_ERR_EN
//   defined   : first_err captures {a,b,c} of the first mismatch of a run
//   undefined : first_err is tied to zero
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   begins a run when idle or done; ignored while busy
//   a, b      out  operands to the adder
//   valid     out  operands valid this cycle
//   c         in   adder result (WIDTH+1 bits)
//   busy      out  run in progress (RUN or DRAIN)
//   done      out  run finished, held until next start
//   pass      out  done with no mismatches
//   txn_count out  transactions issued this run
//   err_count out  mismatches this run, saturating at 255
//   first_err out  {a,b,c} of the first mismatch, zero if none
// -----------------------------------------------------------------------------
module adder_traffic_gen
    import adder_tg_pkg::*;
#(
    parameter int                WIDTH         = 4,
    parameter int                ADDER_LATENCY = 1,
    parameter int                NUM_TXN       = 16,
    parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               valid,
    input  logic [WIDTH:0]     c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [3*WIDTH:0]   first_err
);

    localparam int               SUM_W      = WIDTH + 1;
    localparam int               EXP_PIPE_W = ADDER_LATENCY * SUM_W;
    localparam logic [CNT_W-1:0] LAST_TXN   = CNT_W'(NUM_TXN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [2:0]       DRAIN_LAST = 3'(ADDER_LATENCY - 1);

    tg_state_e         state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [CNT_W-1:0]  txn_q, txn_d, err_q, err_d;
    logic [2:0]        drain_q, drain_d;

    logic [ADDER_LATENCY-1:0][WIDTH:0] exp_pipe_q, exp_pipe_d;
    logic [ADDER_LATENCY-1:0]          tag_pipe_q, tag_pipe_d;

    logic              clear_s;
    logic              lfsr_step_s;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_next_s;
    logic [WIDTH:0]    sum_new_s;
    logic [WIDTH:0]    exp_out_s;
    logic              tag_out_s;
    logic              mismatch_s;

    // A run starts (and all run state clears) only from IDLE or DONE.
    assign clear_s     = start && ((state_q == IDLE) || (state_q == DONE));
    assign lfsr_next_s = lfsr_advance(lfsr_q);
    assign sum_new_s   = {1'b0, a_q} + {1'b0, b_q};
    assign exp_out_s   = exp_pipe_q[ADDER_LATENCY-1];
    assign tag_out_s   = tag_pipe_q[ADDER_LATENCY-1];
    assign mismatch_s  = tag_out_s && (c != exp_out_s);

    lfsr16 #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (clear_s),
        .seed  (SEED),
        .step  (lfsr_step_s),
        .q     (lfsr_q)
    );

    // Run control: next state, operand generation, counters.
    always_comb begin
        state_d     = state_q;
        lfsr_step_s = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        valid_d     = 1'b0;
        txn_d       = txn_q;
        drain_d     = drain_q;
        if (mismatch_s && (err_q != CNT_MAX)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
        case (state_q)
            IDLE, DONE: begin
                if (clear_s) begin
                    // The first pair comes straight from the seed, so the
                    // LFSR (reloaded now) and a/b stay in step.
                    state_d = RUN;
                    valid_d = 1'b1;
                    a_d     = WIDTH'(SEED);
                    b_d     = WIDTH'(SEED >> WIDTH);
                    txn_d   = 8'd0;
                    err_d   = 8'd0;
                    drain_d = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                // txn_q counts pairs already accepted by the adder; the pair
                // on the bus now is transaction txn_q+1.
                txn_d = txn_q + 8'd1;
                if (txn_q == LAST_TXN) begin
                    state_d = DRAIN;
                    drain_d = 3'd0;
                end else begin
                    valid_d     = 1'b1;
                    lfsr_step_s = 1'b1;
                    a_d         = WIDTH'(lfsr_next_s);
                    b_d         = WIDTH'(lfsr_next_s >> WIDTH);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they are registered yet aligned.
    always_comb begin
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    // Expected-sum delay line; the tag marks slots that carry a real transaction.
    always_comb begin
        if (clear_s) begin
            exp_pipe_d = '0;
            tag_pipe_d = '0;
        end else begin
            exp_pipe_d = EXP_PIPE_W'({exp_pipe_q, sum_new_s});
            tag_pipe_d = ADDER_LATENCY'({tag_pipe_q, valid_q});
        end
    end

    // Main state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            txn_q      <= 8'd0;
            err_q      <= 8'd0;
            drain_q    <= 3'd0;
            exp_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            txn_q      <= txn_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
            exp_pipe_q <= exp_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

`ifdef ADDER_TG_FIRST_ERR_EN
    localparam int AB_PIPE_W = ADDER_LATENCY * 2 * WIDTH;

    logic [ADDER_LATENCY-1:0][2*WIDTH-1:0] ab_pipe_q, ab_pipe_d;
    logic [3*WIDTH:0]                      first_err_q, first_err_d;

    // Operands travel with their expected sum; capture only on the first miss.
    always_comb begin
        if (clear_s) begin
            ab_pipe_d   = '0;
            first_err_d = '0;
        end else begin
            ab_pipe_d = AB_PIPE_W'({ab_pipe_q, a_q, b_q});
            if (mismatch_s && (err_q == 8'd0)) begin
                first_err_d = {ab_pipe_q[ADDER_LATENCY-1], c};
            end else begin
                first_err_d = first_err_q;
            end
        end
    end

    // First-error capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ab_pipe_q   <= '0;
            first_err_q <= '0;
        end else begin
            ab_pipe_q   <= ab_pipe_d;
            first_err_q <= first_err_d;
        end
    end

    assign first_err = first_err_q;
`else
    assign first_err = '0;
`endif

    assign a         = a_q;
    assign b         = b_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign txn_count = txn_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_adder_traffic_gen.sv
`timescale 1ns/1ps
module tb_adder_traffic_gen;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   mode = 0;   // 0 ideal adder, 1 output stuck at 0, 2 carry bit forced 0

    logic [W-1:0] a, b, a2, b2;
    logic         valid, valid2, busy, busy2, done, done2, pass, pass2;
    logic [W:0]   c, c2;
    logic [7:0]   txn, txn2, err, err2;
    logic [3*W:0] first_err, first_err2;

    int tests = 0;
    int fails = 0;
    int n;
    logic [7:0] prev;
    logic [3*W:0] fe_exp;

    logic [3:0] exp_a [4] = '{4'h1, 4'h0, 4'h8, 4'hC};
    logic [3:0] exp_b [4] = '{4'hE, 4'h7, 4'h3, 4'h9};

    always #5 clk = ~clk;

    adder_traffic_gen #(.WIDTH(W), .ADDER_LATENCY(1), .NUM_TXN(16), .SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .valid(valid), .c(c),
        .busy(busy), .done(done), .pass(pass), .txn_count(txn), .err_count(err),
        .first_err(first_err)
    );

    adder_traffic_gen #(.WIDTH(W), .ADDER_LATENCY(1), .NUM_TXN(16), .SEED(16'h00FF)) dut_ff (
        .clk(clk), .reset(reset), .start(start), .a(a2), .b(b2), .valid(valid2), .c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .txn_count(txn2), .err_count(err2),
        .first_err(first_err2)
    );

    function automatic logic [W:0] adder_model(input logic [W-1:0] x, input logic [W-1:0] y, input int m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        case (m)
            1:       return 5'h00;
            2:       return {1'b0, s[W-1:0]};
            default: return s;
        endcase
    endfunction

    // Registered adders, latency 1.
    always @(posedge clk) begin
        c  <= adder_model(a, b, mode);
        c2 <= adder_model(a2, b2, mode);
    end

    task pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task wait_done;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task test_reset;
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({a, b, valid, busy, done, pass, txn, err, first_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got a=%h b=%h v=%b busy=%b done=%b pass=%b txn=%0d err=%0d fe=%h, expected all 0",
                     a, b, valid, busy, done, pass, txn, err, first_err);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: got valid/busy/done=%b%b%b expected 000", valid, busy, done);
        end
    endtask

    task test_nominal;
        mode = 0;
        pulse_start;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({valid, a, b, txn} !== {1'b1, exp_a[i], exp_b[i], 8'(i)}) begin
                fails++;
                $display("FAIL pair%0d: got v=%b a=%h b=%h txn=%0d expected v=1 a=%h b=%h txn=%0d",
                         i, valid, a, b, txn, exp_a[i], exp_b[i], i);
            end
            @(negedge clk);
        end
        wait_done;
        tests++;
        if (n !== 13) begin
            fails++;
            $display("FAIL done_latency: got %0d expected 13", n);
        end
        tests++;
        if ({done, pass, busy, valid, txn, err, first_err} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd16, 8'd0, 13'h0}) begin
            fails++;
            $display("FAIL nominal_result: got done=%b pass=%b busy=%b valid=%b txn=%0d err=%0d fe=%h expected 1 1 0 0 16 0 0",
                     done, pass, busy, valid, txn, err, first_err);
        end
    endtask

    task test_stuck_zero;
        mode = 1;
        pulse_start;
        tests++;
        if ({done, pass, txn, err} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL restart_clear: got done=%b pass=%b txn=%0d err=%0d expected 0 0 0 0", done, pass, txn, err);
        end
        wait_done;
        tests++;
        if ({done, pass, err} !== {1'b1, 1'b0, 8'd16}) begin
            fails++;
            $display("FAIL stuck_result: got done=%b pass=%b err=%0d expected done=1 pass=0 err=16", done, pass, err);
        end
`ifdef ADDER_TG_FIRST_ERR_EN
        fe_exp = {4'h1, 4'hE, 5'h00};
`else
        fe_exp = 13'h0;
`endif
        tests++;
        if (first_err !== fe_exp) begin
            fails++;
            $display("FAIL stuck_first_err: got %h expected %h", first_err, fe_exp);
        end
    endtask

    task test_carry;
        mode = 2;
        pulse_start;
        tests++;
        if ({valid2, a2, b2} !== {1'b1, 4'hF, 4'hF}) begin
            fails++;
            $display("FAIL carry_operands: got v=%b a=%h b=%h expected v=1 a=f b=f", valid2, a2, b2);
        end
        wait_done;
        tests++;
        if (!(done2 === 1'b1 && pass2 === 1'b0 && err2 >= 8'd1)) begin
            fails++;
            $display("FAIL carry_result: got done=%b pass=%b err=%0d expected done=1 pass=0 err>=1", done2, pass2, err2);
        end
`ifdef ADDER_TG_FIRST_ERR_EN
        fe_exp = {4'hF, 4'hF, 5'h0E};
`else
        fe_exp = 13'h0;
`endif
        tests++;
        if (first_err2 !== fe_exp) begin
            fails++;
            $display("FAIL carry_first_err: got %h expected %h", first_err2, fe_exp);
        end
    endtask

    task test_mid_reset;
        mode = 0;
        pulse_start;
        n = 0;
        while (txn !== 8'd7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (txn !== 8'd7) begin
            fails++;
            $display("FAIL reach_txn7: got %0d expected 7", txn);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({a, b, valid, busy, done, pass, txn, err, first_err} !== '0) begin
            fails++;
            $display("FAIL abort_outputs: got a=%h b=%h v=%b busy=%b done=%b txn=%0d err=%0d expected all 0",
                     a, b, valid, busy, done, txn, err);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL abort_idle: got valid/busy/done=%b%b%b expected 000", valid, busy, done);
        end
        pulse_start;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({a, b} !== {exp_a[i], exp_b[i]}) begin
                fails++;
                $display("FAIL repeat_pair%0d: got a=%h b=%h expected a=%h b=%h", i, a, b, exp_a[i], exp_b[i]);
            end
            @(negedge clk);
        end
        wait_done;
        tests++;
        if ({done, pass, txn} !== {1'b1, 1'b1, 8'd16}) begin
            fails++;
            $display("FAIL after_abort_result: got done=%b pass=%b txn=%0d expected 1 1 16", done, pass, txn);
        end
    endtask

    task test_start_while_busy;
        mode = 0;
        pulse_start;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        prev = txn;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            tests++;
            if (txn < prev) begin
                fails++;
                $display("FAIL txn_monotonic: got %0d after %0d expected non-decreasing", txn, prev);
            end
            prev = txn;
        end
        tests++;
        if ({done, pass, txn, err} !== {1'b1, 1'b1, 8'd16, 8'd0}) begin
            fails++;
            $display("FAIL busy_start_result: got done=%b pass=%b txn=%0d err=%0d expected 1 1 16 0", done, pass, txn, err);
        end
    endtask

    task test_back_to_back;
        mode = 0;
        pulse_start;
        tests++;
        if ({done, pass, valid, a, b, txn, err} !== {1'b0, 1'b0, 1'b1, 4'h1, 4'hE, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL second_start: got done=%b pass=%b v=%b a=%h b=%h txn=%0d err=%0d expected 0 0 1 1 e 0 0",
                     done, pass, valid, a, b, txn, err);
        end
        wait_done;
        tests++;
        if ({done, pass, txn, err} !== {1'b1, 1'b1, 8'd16, 8'd0}) begin
            fails++;
            $display("FAIL second_result: got done=%b pass=%b txn=%0d err=%0d expected 1 1 16 0", done, pass, txn, err);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_stuck_zero;
        test_carry;
        test_mid_reset;
        test_start_while_busy;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/adder_traffic_gen.md
Name: adder_traffic_gen

Overview:
- Synthesizable initiator/checker for the registered adder's a/b/valid/c interface.
- Drives the adder's operand side on its own: pseudo-random operands, a fixed transaction count, one valid pulse per operand pair.
- Samples c after the adder latency and compares it against a locally computed sum.
- Allows on-chip/FPGA self-test of the adder without the class-based bench; sits beside the adder DUT and drives the same interface signals as the software driver.

Parameters:
- WIDTH, 4, operand width of a and b; legal range 1..8.
- ADDER_LATENCY, 1, cycles from valid-high sample edge to c holding that sum; legal range 1..4.
- NUM_TXN, 16, transactions per run; legal range 1..255.
- SEED, 16'hACE1, LFSR load value; must be nonzero.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run when idle or done
- a  out  WIDTH  operand A to adder
- b  out  WIDTH  operand B to adder
- valid  out  1  operands valid this cycle
- c  in  WIDTH+1  adder result
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  run finished; held until next start
- pass  out  1  done and err_count==0
- txn_count  out  8  transactions issued this run
- err_count  out  8  mismatches this run, saturating at 255
- first_err  out  3*WIDTH+1  {a,b,c} of first mismatch; zero if none

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - a, b, valid, busy, done, pass, txn_count, err_count, first_err all 0.
  - LFSR = SEED.
  - Reset mid-run aborts immediately; no partial results are retained.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances once per issued transaction.
  - a = lfsr[WIDTH-1:0], b = lfsr[2*WIDTH-1:WIDTH], taken from the current LFSR value.
- State IDLE:
  - start=1 -> RUN.
  - On entry to RUN: LFSR reloads SEED, both counters clear, first_err clears, done/pass clear.
  - Every run is therefore repeatable.
- State RUN:
  - valid=1 every cycle; a/b present a new pair each cycle; txn_count increments per cycle.
  - After the cycle that issues transaction NUM_TXN: valid=0, a/b hold their last value, -> DRAIN.
- State DRAIN:
  - Wait ADDER_LATENCY cycles so the final result is checked, then -> DONE.
- State DONE:
  - done=1; pass=(err_count==0).
  - start=1 -> RUN, with the same clears as from IDLE.
- start while busy: ignored.
- Checking:
  - Expected sum = zero-extended a + zero-extended b, WIDTH+1 bits, computed when valid=1.
  - Expected sum plus a valid tag go through an ADDER_LATENCY-deep shift register.
  - When the tag emerges, compare against c in that cycle.
  - On mismatch: err_count+1, saturating at 255.
- Boundary conditions:
  - NUM_TXN=1: one valid cycle, then DRAIN.
  - All-ones operands: sum carries into bit WIDTH; the full WIDTH+1 bits are compared.
  - Check and DRAIN exit in the same cycle: the check is counted before done asserts.

Optional Feature:
- Macro: ADDER_TG_FIRST_ERR_EN.
- Defined:
  - first_err captures {a,b,c} of the first mismatch in a run.
  - The capture requires a and b to be carried in the shift register alongside the expected sum.
  - first_err holds until the next start or reset.
- Undefined:
  - first_err tied to 0.
  - The shift register carries only sum and tag.

Decomposition:
- Package adder_tg_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - LFSR_W=16
  - LFSR_TAPS=16'hB400
  - DEFAULT_SEED
  - CNT_W=8
- Sub-module lfsr16:
  - Ports: clk, reset, load, seed, step, q.
  - Galois shift with reload.

Test Plan:
- Reset then start with an ideal adder model, ADDER_LATENCY=1:
  - first cycle a=4'h1, b=4'hE, expected c=5'h0F.
  - After 16+1+1 cycles: done=1, pass=1, txn_count=16, err_count=0.
- Adder output stuck at c=0:
  - err_count=16 (no pair in the default sequence sums to zero), pass=0.
  - With ADDER_TG_FIRST_ERR_EN: first_err={4'h1,4'hE,5'h00}.
- Adder with carry bit forced to 0, operands a=b=4'hF forced by SEED=16'h00FF:
  - expected 5'h1E, c=5'h0E -> err_count>=1.
- Assert reset at txn_count=7:
  - all outputs 0 within the same cycle, state IDLE.
  - A later start repeats an identical operand sequence.
- start pulse while busy:
  - no effect; txn_count continues monotonically to 16.
- Second start after DONE:
  - counters clear, same first operands 1/E; results identical to the first run.
